branch_predictor: RTL and testbench

Dynamic conditional-branch predictor and resolution checker that drives the fetch unit's prediction and recovery inputs. At fetch it looks up the current PC in a direct-mapped branch target buffer (BTB) and a pattern history table (PHT) of 2-bit saturating counters. It then presents `predict_taken`, `predict_target` and `target_valid` in the same cycle. At execute it compares each resolved conditional branch against the prediction carried down the pipeline, raises `flush`/`correct_pc` on a mismatch, and trains both tables. Unconditional jumps are outside this block's scope.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/branch_predictor_if.sv | 34 +++
 rtl/branch_btb.sv | 48 ++++
 rtl/branch_predictor.sv | 112 +++++++++++
 tb/tb_branch_predictor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared encodings and defaults for the branch predictor slice.
// The optional BP_GSHARE_EN build is handled in the top level; nothing here depends on it.
package bp_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_TAG_BITS   = 8;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Saturating 2-bit counter step toward the resolved outcome
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        case (cur)
            SNT:     ctr_next = taken ? WNT : SNT;
            WNT:     ctr_next = taken ? WT  : SNT;
            WT:      ctr_next = taken ? ST  : WNT;
            ST:      ctr_next = taken ? ST  : WT;
            default: ctr_next = CTR_RESET;
        endcase
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bus of the branch predictor.
// master = pipeline (fetch + execute), slave = predictor.
interface branch_predictor_if;

    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        target_valid;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        flush;
    logic [31:0] correct_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output fetch_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  predict_taken, predict_target, target_valid, flush, correct_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output predict_taken, predict_target, target_valid, flush, correct_pc,
               branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_btb.sv
// Direct-mapped branch target buffer: combinational read with tag hit,
// one synchronous write port, asynchronous reset.
module branch_btb
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_target,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_target
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [31:0]         target_r [ENTRIES];

    // Read port: target is presented regardless of hit; no write bypass
    always_comb begin
        rd_target = target_r[rd_idx];
        rd_hit    = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    end

    // Entry storage; a write replaces whatever occupies the slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 32'd0;
            end
        end else if (wr_en) begin
            valid_r[wr_idx]  <= 1'b1;
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal (or gshare when BP_GSHARE_EN is defined) conditional branch predictor
// with execute-stage mispredict detection, table training and statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic               clock,
    input  logic               reset,
    branch_predictor_if.slave  bus
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    ctr_e                  pht_r [ENTRIES];
    logic [INDEX_BITS-1:0] fetch_idx_s;
    logic [INDEX_BITS-1:0] ex_idx_s;
    logic [INDEX_BITS-1:0] pht_rd_idx_s;
    logic [INDEX_BITS-1:0] pht_wr_idx_s;
    logic                  mispredict_s;
    logic [31:0]           correct_pc_s;
    logic [31:0]           branch_count_r;
    logic [31:0]           mispredict_count_r;
    logic                  unused_pc_bits_s;

    assign fetch_idx_s      = bus.fetch_pc[INDEX_BITS+1:2];
    assign ex_idx_s         = bus.ex_pc[INDEX_BITS+1:2];
    assign unused_pc_bits_s = ^{bus.fetch_pc[1:0], bus.fetch_pc[31:INDEX_BITS+TAG_BITS+2]};

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_r;

    assign pht_rd_idx_s = fetch_idx_s ^ ghr_r;
    assign pht_wr_idx_s = ex_idx_s ^ ghr_r;

    // Non-speculative history: only resolved branches shift in
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_r <= '0;
        end else if (bus.ex_valid) begin
            ghr_r <= {ghr_r[INDEX_BITS-2:0], bus.ex_taken};
        end else begin
            ghr_r <= ghr_r;
        end
    end
`else
    assign pht_rd_idx_s = fetch_idx_s;
    assign pht_wr_idx_s = ex_idx_s;
`endif

    branch_btb #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_btb (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (fetch_idx_s),
        .rd_tag    (bus.fetch_pc[INDEX_BITS+2 +: TAG_BITS]),
        .rd_hit    (bus.target_valid),
        .rd_target (bus.predict_target),
        .wr_en     (bus.ex_valid && bus.ex_taken),
        .wr_idx    (ex_idx_s),
        .wr_tag    (bus.ex_pc[INDEX_BITS+2 +: TAG_BITS]),
        .wr_target (bus.ex_target)
    );

    assign bus.predict_taken = pht_r[pht_rd_idx_s][1];

    // Mispredict detection and recovery address
    always_comb begin
        mispredict_s = 1'b0;
        correct_pc_s = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
        if (bus.ex_valid) begin
            mispredict_s = (bus.ex_pred_taken != bus.ex_taken) ||
                           (bus.ex_taken && (bus.ex_pred_target != bus.ex_target));
        end else begin
            mispredict_s = 1'b0;
        end
    end

    assign bus.flush            = mispredict_s;
    assign bus.correct_pc       = correct_pc_s;
    assign bus.branch_count     = branch_count_r;
    assign bus.mispredict_count = mispredict_count_r;

    // PHT training; a same-cycle flush does not block the update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_r[i] <= CTR_RESET;
            end
        end else if (bus.ex_valid) begin
            pht_r[pht_wr_idx_s] <= ctr_next(pht_r[pht_wr_idx_s], bus.ex_taken);
        end
    end

    // Resolution statistics, wrapping at 2^32
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else if (bus.ex_valid) begin
            branch_count_r     <= branch_count_r + 32'd1;
            mispredict_count_r <= mispredict_count_r + {31'd0, mispredict_s};
        end else begin
            branch_count_r     <= branch_count_r;
            mispredict_count_r <= mispredict_count_r;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (default bimodal build): directed vectors
// push expected values, a negedge monitor pops and compares them.
module tb_branch_predictor;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    branch_predictor_if bus ();

    branch_predictor #(
        .INDEX_BITS (6),
        .TAG_BITS   (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {F_PT, F_TV, F_TGT, F_FLUSH, F_CPC, F_BC, F_MC} field_e;
    typedef struct {
        string       name;
        field_e      field;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] observe(input field_e f);
        case (f)
            F_PT:    observe = {31'd0, bus.predict_taken};
            F_TV:    observe = {31'd0, bus.target_valid};
            F_TGT:   observe = bus.predict_target;
            F_FLUSH: observe = {31'd0, bus.flush};
            F_CPC:   observe = bus.correct_pc;
            F_BC:    observe = bus.branch_count;
            F_MC:    observe = bus.mispredict_count;
            default: observe = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare everything queued for the current cycle on the falling edge
    always begin
        exp_t        e;
        logic [31:0] act;
        @(negedge clock);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = observe(e.field);
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic push(input string n, input field_e f, input logic [31:0] v);
        exp_t e;
        e.name  = n;
        e.field = f;
        e.exp   = v;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.ex_valid       = v;
        bus.ex_pc          = pc;
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
    endtask

    task automatic expect_lookup(input string n, input logic pt, input logic tv,
                                 input logic [31:0] tgt);
        push({n, "_pt"},  F_PT,  {31'd0, pt});
        push({n, "_tv"},  F_TV,  {31'd0, tv});
        push({n, "_tgt"}, F_TGT, tgt);
    endtask

    task automatic expect_counts(input string n, input logic [31:0] bc, input logic [31:0] mc);
        push({n, "_bc"}, F_BC, bc);
        push({n, "_mc"}, F_MC, mc);
    endtask

    task automatic expect_resolve(input string n, input logic fl, input logic [31:0] cpc);
        push({n, "_flush"}, F_FLUSH, {31'd0, fl});
        push({n, "_cpc"},   F_CPC,   cpc);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_pc = 32'h0000_0040;
        drive_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Post-reset lookup
        expect_lookup("rst", 1'b0, 1'b0, 32'd0);
        push("rst_flush", F_FLUSH, 32'd0);
        expect_counts("rst", 32'd0, 32'd0);
        step();

        // First taken resolution mispredicted; same-cycle lookup sees old contents
        drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_resolve("first", 1'b1, 32'h80);
        expect_lookup("first_pre", 1'b0, 1'b0, 32'd0);
        step();
        drive_ex(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_lookup("first_post", 1'b1, 1'b1, 32'h80);
        expect_counts("first_post", 32'd1, 32'd1);
        step();

        // Four correctly predicted taken resolutions, counter saturates at 3
        for (int i = 0; i < 4; i++) begin
            drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
            push("taken_ok_flush", F_FLUSH, 32'd0);
            step();
        end

        // Not-taken while predicted taken: 3 -> 2, still predicts taken
        drive_ex(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        expect_resolve("nt_mp", 1'b1, 32'h44);
        step();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_lookup("after_nt", 1'b1, 1'b1, 32'h80);
        expect_counts("after_nt", 32'd6, 32'd2);
        step();

        // Same index, different tag: BTB miss, shared PHT counter
        bus.fetch_pc = 32'h0000_0140;
        push("alias_tv", F_TV, 32'd0);
        push("alias_pt", F_PT, 32'd1);
        step();
        bus.fetch_pc = 32'h0000_0040;

        // Direction right, target wrong
        drive_ex(1'b1, 32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
        expect_resolve("tgt_mp", 1'b1, 32'hC0);
        step();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_lookup("after_tgt", 1'b1, 1'b1, 32'hC0);
        expect_counts("after_tgt", 32'd7, 32'd3);
        step();

        // Correct not-taken ignores stale predicted target
        drive_ex(1'b1, 32'h200, 1'b0, 32'h999, 1'b0, 32'h1234);
        expect_resolve("nt_ok", 1'b0, 32'h204);
        step();

        // Fall-through address wraps at 2^32
        drive_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        expect_resolve("wrap", 1'b1, 32'h0);
        step();

        // Mismatching ex fields without ex_valid never flush
        drive_ex(1'b0, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
        push("novalid_flush", F_FLUSH, 32'd0);
        expect_counts("novalid", 32'd9, 32'd4);
        step();

        // Asynchronous reset between edges
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        expect_lookup("async_rst", 1'b0, 1'b0, 32'd0);
        push("async_rst_flush", F_FLUSH, 32'd0);
        expect_counts("async_rst", 32'd0, 32'd0);
        step();
        reset = 1'b0;
        expect_lookup("post_rst", 1'b0, 1'b0, 32'd0);
        step();

        // First training after reset behaves as from a clean state
        drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_resolve("retrain", 1'b1, 32'h80);
        step();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_lookup("retrain_post", 1'b1, 1'b1, 32'h80);
        expect_counts("retrain_post", 32'd1, 32'd1);
        step();
        step();

        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
